// File: rtl/if_prefetch_hs.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_hs
// Purpose  : Instruction-fetch front end. Runs a PC, reads a 1-cycle-latency
//            instruction memory, buffers fetched words in a DEPTH-entry
//            prefetch queue and hands {pc,instr} to ID over a 4-phase
//            req/ack channel whose ack arrives from another clock domain.
//            Branch redirects flush the queue and any fetch in flight.
// Ports    : clk_if       fetch clock (posedge)
//            reset        asynchronous active-high reset
//            imem_rd_en   memory read strobe, address sampled on this edge
//            imem_addr    memory read address (current PC)
//            imem_rdata   memory read data, valid the cycle after the strobe
//            branch_en    redirect pulse from ID
//            branch_addr  redirect target
//            req_out      4-phase request to ID
//            ack_in       4-phase acknowledge from ID (asynchronous)
//            instr_out    instruction of the head entry (0 when empty)
//            pc_out       PC of the head entry (0 when empty)
//            q_count      number of entries held in the queue
// Revision : 1.0  initial release
// ============================================================================
module if_prefetch_hs #(
    parameter int          INSTR_W     = 32,
    parameter int          PC_W        = 8,
    parameter int          DEPTH       = 4,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                       clk_if,
    input  logic                       reset,
    output logic                       imem_rd_en,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       branch_en,
    input  logic [PC_W-1:0]            branch_addr,
    output logic                       req_out,
    input  logic                       ack_in,
    output logic [INSTR_W-1:0]         instr_out,
    output logic [PC_W-1:0]            pc_out,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [PC_W-1:0]   c_reset_pc = PC_W'(RESET_PC);
    localparam logic [PTR_W-1:0]  c_ptr_one  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  c_depth    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } hs_state_t;

    // Registered state
    logic [PC_W-1:0]        pc_q,        pc_d;
    logic [PC_W-1:0]        fetch_pc_q,  fetch_pc_d;
    logic                   inflight_q,  inflight_d;
    logic [PTR_W-1:0]       head_q,      head_d;
    logic [PTR_W-1:0]       tail_q,      tail_d;
    logic [CNT_W-1:0]       count_q,     count_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    hs_state_t              state_q;
    logic                   req_q;

    logic [INSTR_W-1:0]     buf_instr_q [DEPTH];
    logic [PC_W-1:0]        buf_pc_q    [DEPTH];

    // Combinational control
    logic                   ack_s;
    logic                   ack_chain_low;
    logic [CNT_W-1:0]       fill;
    logic                   issue;
    logic                   push;
    logic                   pop;

    always_comb begin
        ack_s         = ack_sync_q[SYNC_STAGES-1];
        // A new request needs ack seen low through the whole chain. Right
        // after reset the later stages still hold their reset zeros, so this
        // stops a stale high ack (already in the first stage) from being
        // mistaken for a low one and then popping the next entry.
        ack_chain_low = (ack_sync_q == '0);

        // Slots already promised to an in-flight read count as occupied, so
        // a push can never land on a full queue.
        fill  = count_q + {{PTR_W{1'b0}}, inflight_q};
        issue = !reset && !branch_en && (fill < c_depth);
        push  = inflight_q && !branch_en;
        pop   = (state_q == ST_REQ) && ack_s;

        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = issue;
        if (branch_en) begin
            pc_d = branch_addr;
        end else if (issue) begin
            pc_d       = pc_q + 1'b1;
            fetch_pc_d = pc_q;
        end

        head_d  = pop  ? head_q + c_ptr_one : head_q;
        tail_d  = push ? tail_q + c_ptr_one : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (branch_en) begin
            // A head already offered to ID must finish its handshake, so
            // it survives the flush; everything behind it is dropped.
            if ((state_q == ST_REQ) && !pop) begin
                tail_d  = head_q + c_ptr_one;
                count_d = CNT_W'(1);
            end else begin
                tail_d  = head_d;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk_if or posedge reset) begin
        if (reset) begin
            pc_q       <= c_reset_pc;
            fetch_pc_q <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ack_sync_q <= '0;
        end else begin
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
        end
    end

    // Queue storage needs no reset: slots are only read while occupied.
    always_ff @(posedge clk_if) begin
        if (push) begin
            buf_instr_q[tail_q] <= imem_rdata;
            buf_pc_q[tail_q]    <= fetch_pc_q;
        end
    end

    // Handshake FSM. IDLE looks at the post-edge count so the first word
    // pushed is offered on the very next cycle.
    always_ff @(posedge clk_if or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((count_d != '0) && ack_chain_low) begin
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        state_q <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!ack_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_rd_en = issue;
    assign imem_addr  = pc_q;
    assign req_out    = req_q;
    assign q_count    = count_q;
    assign instr_out  = (count_q == '0) ? '0 : buf_instr_q[head_q];
    assign pc_out     = (count_q == '0) ? '0 : buf_pc_q[head_q];

    a_no_push_when_full : assert property (
        @(posedge clk_if) disable iff (reset) !(push && (count_q == c_depth))
    );

endmodule
`default_nettype wire
